// File: rtl/div_pkg.sv
// Shared definitions for the div block: FSM state encodings and the
// constants reported for a divide-by-zero result.
package div_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_CALC = 2'd1;
    localparam state_t S_DONE = 2'd2;

    // Divide-by-zero result: quotient filled with this bit, remainder with the other.
    localparam logic DZ_Q_BIT = 1'b1;
    localparam logic DZ_R_BIT = 1'b0;
    localparam logic DZ_FLAG  = 1'b1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference if it did not borrow.
module div_step #(
    parameter int D_WIDTH = 16
) (
    input  logic [D_WIDTH-1:0] rem_i,
    input  logic [D_WIDTH-1:0] div_i,
    input  logic               bit_i,
    output logic [D_WIDTH-1:0] rem_o,
    output logic               q_bit_o
);

    logic [D_WIDTH:0] w_shift;
    logic [D_WIDTH:0] w_diff;

    // Partial remainder is always below the divisor, so one extra bit
    // is enough for the borrow to act as the compare result.
    assign w_shift = {rem_i, bit_i};
    assign w_diff  = w_shift - {1'b0, div_i};
    assign q_bit_o = ~w_diff[D_WIDTH];
    assign rem_o   = q_bit_o ? w_diff[D_WIDTH-1:0] : w_shift[D_WIDTH-1:0];

endmodule

// File: rtl/div.sv
// Iterative restoring divider, one quotient bit per enabled cycle.
// Define DIV_SIGNED_EN for two's-complement operands (truncate toward zero).
module div
    import div_pkg::*;
#(
    parameter int N_WIDTH = 16,
    parameter int D_WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    input  logic               start_i,
    output logic               ready_o,
    input  logic [N_WIDTH-1:0] n_i,
    input  logic [D_WIDTH-1:0] d_i,
    output logic [N_WIDTH-1:0] q_o,
    output logic [D_WIDTH-1:0] r_o,
    output logic               valid_o,
    output logic               dz_o
);

    localparam int CW = $clog2(N_WIDTH + 1);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [N_WIDTH-1:0] r_quo;
    logic [D_WIDTH-1:0] r_rem;
    logic [D_WIDTH-1:0] r_div;
    logic               r_dz;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [N_WIDTH-1:0] r_q;
    logic [D_WIDTH-1:0] r_r;
    logic               r_dz_o;
    logic               r_valid;

    logic [N_WIDTH-1:0] w_n_mag;
    logic [D_WIDTH-1:0] w_d_mag;
    logic               w_neg_q;
    logic               w_neg_r;
    logic [N_WIDTH-1:0] w_q_fin;
    logic [D_WIDTH-1:0] w_r_fin;
    logic [D_WIDTH-1:0] w_rem_next;
    logic               w_q_bit;

`ifdef DIV_SIGNED_EN
    // Magnitudes are taken on acceptance and signs restored in DONE, so the
    // core loop stays unsigned and the latency is unchanged.
    assign w_n_mag = n_i[N_WIDTH-1] ? -n_i : n_i;
    assign w_d_mag = d_i[D_WIDTH-1] ? -d_i : d_i;
    assign w_neg_q = n_i[N_WIDTH-1] ^ d_i[D_WIDTH-1];
    assign w_neg_r = n_i[N_WIDTH-1];
`else
    assign w_n_mag = n_i;
    assign w_d_mag = d_i;
    assign w_neg_q = 1'b0;
    assign w_neg_r = 1'b0;
`endif

    assign w_q_fin = r_neg_q ? -r_quo : r_quo;
    assign w_r_fin = r_neg_r ? -r_rem : r_rem;

    div_step #(.D_WIDTH(D_WIDTH)) u_step (
        .rem_i   (r_rem),
        .div_i   (r_div),
        .bit_i   (r_quo[N_WIDTH-1]),
        .rem_o   (w_rem_next),
        .q_bit_o (w_q_bit)
    );

    assign ready_o = (r_state == S_IDLE);
    assign q_o     = r_q;
    assign r_o     = r_r;
    assign dz_o    = r_dz_o;
    assign valid_o = r_valid;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_dz    <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_q     <= '0;
            r_r     <= '0;
            r_dz_o  <= 1'b0;
            r_valid <= 1'b0;
        end else if (en_i) begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_state <= S_CALC;
                        r_cnt   <= CW'(N_WIDTH);
                        r_quo   <= w_n_mag;
                        r_rem   <= '0;
                        r_div   <= w_d_mag;
                        r_dz    <= (d_i == '0);
                        r_neg_q <= w_neg_q;
                        r_neg_r <= w_neg_r;
                    end
                end
                S_CALC: begin
                    // Quotient bits shift in from the right as dividend bits leave on the left.
                    r_quo <= {r_quo[N_WIDTH-2:0], w_q_bit};
                    r_rem <= w_rem_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b1;
                    if (r_dz) begin
                        r_q    <= {N_WIDTH{DZ_Q_BIT}};
                        r_r    <= {D_WIDTH{DZ_R_BIT}};
                        r_dz_o <= DZ_FLAG;
                    end else begin
                        r_q    <= w_q_fin;
                        r_r    <= w_r_fin;
                        r_dz_o <= ~DZ_FLAG;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div at N_WIDTH=D_WIDTH=8 against an arithmetic model.
// Signed checks are included when DIV_SIGNED_EN is defined.
module tb_div;

    logic       clk = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       en_i = 1'b1;
    logic       start_i = 1'b0;
    logic       ready_o;
    logic [7:0] n_i = '0;
    logic [7:0] d_i = '0;
    logic [7:0] q_o;
    logic [7:0] r_o;
    logic       valid_o;
    logic       dz_o;

    int n_tests = 0;
    int n_fail  = 0;

    div #(.N_WIDTH(8), .D_WIDTH(8)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n_i),
        .en_i    (en_i),
        .start_i (start_i),
        .ready_o (ready_o),
        .n_i     (n_i),
        .d_i     (d_i),
        .q_o     (q_o),
        .r_o     (r_o),
        .valid_o (valid_o),
        .dz_o    (dz_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [7:0] n, input logic [7:0] d,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz);
        if (d == 8'd0) begin
            q = 8'hFF; r = 8'h00; dz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            int ni, di;
            ni = int'($signed(n));
            di = int'($signed(d));
            q = 8'(ni / di);
            r = 8'(ni % di);
`else
            q = n / d;
            r = n % d;
`endif
            dz = 1'b0;
        end
    endfunction

    // Issue one operation and return what the DUT produced and when.
    task automatic do_op(input logic [7:0] n, input logic [7:0] d, output int lat,
                         output logic [7:0] q, output logic [7:0] r, output logic dz);
        int w = 0;
        while (!ready_o && w < 50) begin tick(); w++; end
        n_i = n; d_i = d; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 50) begin tick(); lat++; end
        q = q_o; r = r_o; dz = dz_o;
    endtask

    task automatic test_reset();
        en_i = 1'b0; rst_n_i = 1'b0;
        tick(); tick();
        n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        n_tests++; if (q_o !== 8'd0 || r_o !== 8'd0 || dz_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs got q=%h r=%h dz=%b exp 0/0/0", q_o, r_o, dz_o);
        end
        rst_n_i = 1'b1; en_i = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat; logic [7:0] q, r; logic dz;
        do_op(8'd100, 8'd7, lat, q, r, dz);
        $display("[TB] basic 100/7 lat=%0d q=%0d r=%0d dz=%b", lat, q, r, dz);
        n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL basic_latency got=%0d exp=9", lat); end
        n_tests++; if (q !== 8'd14 || r !== 8'd2 || dz !== 1'b0) begin
            n_fail++; $display("FAIL basic_result got q=%0d r=%0d dz=%b exp 14/2/0", q, r, dz);
        end
    endtask

    task automatic test_div_zero();
        int lat; logic [7:0] q, r; logic dz;
        do_op(8'd55, 8'd0, lat, q, r, dz);
        $display("[TB] divzero 55/0 lat=%0d q=%0d r=%0d dz=%b", lat, q, r, dz);
        n_tests++; if (lat !== 9) begin n_fail++; $display("FAIL dz_latency got=%0d exp=9", lat); end
        n_tests++; if (q !== 8'hFF || r !== 8'h00 || dz !== 1'b1) begin
            n_fail++; $display("FAIL dz_result got q=%h r=%h dz=%b exp ff/00/1", q, r, dz);
        end
    endtask

    task automatic test_random();
        int lat; logic [7:0] n, d, q, r, eq, er; logic dz, edz;
        for (int i = 0; i < 24; i++) begin
            n = 8'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            model(n, d, eq, er, edz);
            do_op(n, d, lat, q, r, dz);
            $display("[TB] random %0d: %h/%h lat=%0d q=%h r=%h dz=%b", i, n, d, lat, q, r, dz);
            n_tests++; if (lat !== 9 || q !== eq || r !== er || dz !== edz) begin
                n_fail++;
                $display("FAIL random_%0d %h/%h got lat=%0d q=%h r=%h dz=%b exp lat=9 q=%h r=%h dz=%b",
                         i, n, d, lat, q, r, dz, eq, er, edz);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc[$]; int vcyc[$]; logic [7:0] vq[$]; logic [7:0] vr[$];
        int bad = 0; logic pre;
        logic [7:0] q1, r1, q2, r2; logic dz1, dz2;
        model(8'd200, 8'd3, q1, r1, dz1);
        model(8'd9, 8'd10, q2, r2, dz2);
        n_i = 8'd200; d_i = 8'd3; start_i = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            pre = ready_o && start_i;
            tick();
            if (pre) begin
                acc.push_back(cyc);
                if (acc.size() == 1) begin n_i = 8'd9; d_i = 8'd10; end
                else start_i = 1'b0;
            end
            if (valid_o) begin vcyc.push_back(cyc); vq.push_back(q_o); vr.push_back(r_o); end
            foreach (acc[k]) if (cyc >= acc[k] && cyc <= acc[k] + 8 && ready_o) bad++;
        end
        start_i = 1'b0;
        $display("[TB] back_to_back accepts=%0d valids=%0d busy_ready=%0d", acc.size(), vcyc.size(), bad);
        n_tests++; if (acc.size() != 2 || vcyc.size() != 2) begin
            n_fail++; $display("FAIL b2b_counts got acc=%0d valid=%0d exp 2/2", acc.size(), vcyc.size());
        end else begin
            n_tests++; if (acc[1] - acc[0] != 10) begin
                n_fail++; $display("FAIL b2b_spacing got=%0d exp=10", acc[1] - acc[0]);
            end
            n_tests++; if (vcyc[0] - acc[0] != 9 || vcyc[1] - acc[1] != 9) begin
                n_fail++; $display("FAIL b2b_latency got=%0d,%0d exp=9,9", vcyc[0] - acc[0], vcyc[1] - acc[1]);
            end
            n_tests++; if (vq[0] !== q1 || vr[0] !== r1 || vq[1] !== q2 || vr[1] !== r2) begin
                n_fail++; $display("FAIL b2b_results got %0d/%0d %0d/%0d exp %0d/%0d %0d/%0d",
                                   vq[0], vr[0], vq[1], vr[1], q1, r1, q2, r2);
            end
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL b2b_ready_busy got=%0d exp=0", bad); end
    endtask

    task automatic test_stall();
        int cyc = 0; int frozen_bad = 0;
        logic [7:0] sq, sr; logic sdz, sv, srdy;
        while (!ready_o && cyc < 50) begin tick(); cyc++; end
        n_i = 8'd100; d_i = 8'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        cyc = 0;
        repeat (3) begin tick(); cyc++; end
        sq = q_o; sr = r_o; sdz = dz_o; sv = valid_o; srdy = ready_o;
        en_i = 1'b0;
        repeat (5) begin
            tick(); cyc++;
            if (q_o !== sq || r_o !== sr || dz_o !== sdz || valid_o !== sv || ready_o !== srdy) frozen_bad++;
        end
        en_i = 1'b1;
        while (!valid_o && cyc < 60) begin tick(); cyc++; end
        $display("[TB] stall 100/7 valid_cycle=%0d q=%0d r=%0d frozen_bad=%0d", cyc, q_o, r_o, frozen_bad);
        n_tests++; if (frozen_bad != 0) begin n_fail++; $display("FAIL stall_frozen got=%0d exp=0", frozen_bad); end
        n_tests++; if (cyc != 14) begin n_fail++; $display("FAIL stall_latency got=%0d exp=14", cyc); end
        n_tests++; if (q_o !== 8'd14 || r_o !== 8'd2 || valid_o !== 1'b1) begin
            n_fail++; $display("FAIL stall_result got q=%0d r=%0d v=%b exp 14/2/1", q_o, r_o, valid_o);
        end
    endtask

    task automatic test_reset_midop();
        int lat; int vseen = 0; logic [7:0] q, r; logic dz;
        do_op(8'd77, 8'd5, lat, q, r, dz);
        tick();
        n_i = 8'd100; d_i = 8'd7; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        $display("[TB] reset_midop ready=%b valid=%b q=%h r=%h dz=%b", ready_o, valid_o, q_o, r_o, dz_o);
        n_tests++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset_ctrl got ready=%b valid=%b exp 1/0", ready_o, valid_o);
        end
        n_tests++; if (q_o !== 8'd0 || r_o !== 8'd0 || dz_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset_outputs got q=%h r=%h dz=%b exp 0/0/0", q_o, r_o, dz_o);
        end
        repeat (15) begin tick(); if (valid_o) vseen++; end
        n_tests++; if (vseen != 0) begin n_fail++; $display("FAIL midreset_no_valid got=%0d exp=0", vseen); end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        logic [7:0] ns[3] = '{8'h9C, 8'h80, 8'd100};
        logic [7:0] ds[3] = '{8'd7, 8'hFF, 8'hF9};
        logic [7:0] eq[3] = '{8'hF2, 8'h80, 8'hF2};
        logic [7:0] er[3] = '{8'hFE, 8'h00, 8'h02};
        int lat; logic [7:0] q, r; logic dz;
        for (int i = 0; i < 3; i++) begin
            do_op(ns[i], ds[i], lat, q, r, dz);
            $display("[TB] signed %h/%h lat=%0d q=%h r=%h dz=%b", ns[i], ds[i], lat, q, r, dz);
            n_tests++; if (lat !== 9 || q !== eq[i] || r !== er[i] || dz !== 1'b0) begin
                n_fail++; $display("FAIL signed_%0d got lat=%0d q=%h r=%h exp 9 q=%h r=%h", i, lat, q, r, eq[i], er[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midop();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
